// File: rtl/gyruss_audio_decim.sv
// ---------------------------------------------------------------------------
// gyruss_audio_decim
//
// Audio output stage that follows the heavy low-pass filter. It boxcar
// averages the full-rate filter output over 2^LOG2_DIV clocks (1024 clocks at
// 49.152 MHz gives 48 kHz). An optional first-order DC blocker and 16-bit
// saturation come after the averager. Each new sample is flagged with a
// one-clock valid strobe.
//
// Ports:
//   clk        system clock (49.152 MHz)
//   reset      asynchronous, active-high reset
//   in         signed 16-bit sample from the low-pass filter, taken every clk
//   mute       forces the output and the DC blocker state to zero
//   out        signed 16-bit decimated sample, held between strobes
//   out_valid  one-clock pulse on every update of out
// ---------------------------------------------------------------------------
module gyruss_audio_decim #(
   parameter int LOG2_DIV  = 10,
   parameter bit DC_EN     = 1'b1,
   parameter int DCB_SHIFT = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] in,
   input  logic               mute,
   output logic signed [15:0] out,
   output logic               out_valid
);

   localparam int ACC_W = 16 + LOG2_DIV;
   localparam int Y_W   = 19;

   logic        [LOG2_DIV-1:0] cnt;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [15:0]         avg;
   logic signed [15:0]         avg_prev;
   logic signed [15:0]         avg_next;
   logic signed [15:0]         y_prev;
   logic signed [Y_W-1:0]      y;
   logic signed [15:0]         y_sat;
   logic signed [15:0]         out_next;
   logic                       stage;
   logic                       win_close;

   // The window closes on the last count of the cycle. The sample present on
   // that edge still belongs to the closing window, so it is folded into the
   // sum that gets averaged instead of into the accumulator.
   assign win_close = &cnt;

   // Window sum including the current sample. A sum of 2^LOG2_DIV 16-bit
   // samples always fits in 16+LOG2_DIV bits, so no overflow handling is needed.
   // The arithmetic shift makes the average round toward minus infinity.
   always_comb begin
      acc_sum  = acc + {{LOG2_DIV{in[15]}}, in};
      avg_next = 16'(acc_sum >>> LOG2_DIV);
   end

   // DC blocker: y = x[n] - x[n-1] + y[n-1] - y[n-1]*2^-DCB_SHIFT.
   // The 19-bit width covers the worst case of two full-scale differences
   // plus the feedback term. The result is then clamped to 16 bits.
   always_comb begin
      y = Y_W'(avg) - Y_W'(avg_prev) + Y_W'(y_prev) - Y_W'(y_prev >>> DCB_SHIFT);
      if (y > 19'sd32767) begin
         y_sat = 16'sh7FFF;
      end else if (y < -19'sd32768) begin
         y_sat = 16'sh8000;
      end else begin
         y_sat = y[15:0];
      end
   end

   // Value written to out on the output edge. mute overrides both paths.
   // The same value becomes the blocker's feedback state, so releasing mute
   // restarts the blocker from zero.
   always_comb begin
      out_next = out;
      if (mute) begin
         out_next = '0;
      end else if (DC_EN) begin
         out_next = y_sat;
      end else begin
         out_next = avg;
      end
   end

   // Pipeline: window close latches the new average and sets the stage flag.
   // On the following edge the output is computed from the latched averages,
   // and the strobe is raised for exactly that one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         acc       <= '0;
         avg       <= '0;
         avg_prev  <= '0;
         y_prev    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         stage     <= 1'b0;
      end else begin
         cnt       <= cnt + 1'b1;
         out_valid <= stage;
         if (stage) begin
            out    <= out_next;
            y_prev <= out_next;
            stage  <= 1'b0;
         end
         if (win_close) begin
            avg      <= avg_next;
            avg_prev <= avg;
            acc      <= '0;
            stage    <= 1'b1;
         end else begin
            acc <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_gyruss_audio_decim.sv
// ---------------------------------------------------------------------------
// tb_gyruss_audio_decim
//
// Drives one DUT with the DC blocker disabled and one with it enabled from
// the same stimulus. Each window pushes its hand-computed expected result
// (value and output edge number) into a per-DUT queue. A negedge monitor pops
// an entry on every strobe and also checks that out holds between strobes.
// ---------------------------------------------------------------------------
module tb_gyruss_audio_decim;

   logic               clk = 1'b0;
   logic               reset;
   logic               mute;
   logic signed [15:0] in_s;
   logic signed [15:0] out0;
   logic signed [15:0] out1;
   logic               valid0;
   logic               valid1;

   int errors = 0;
   int checks = 0;
   int clk_edges = 0;
   int win_idx = 0;

   typedef struct {
      int                 idx;
      int                 at;
      logic signed [15:0] val;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   logic signed [15:0] last0 = '0;
   logic signed [15:0] last1 = '0;

   // Free-running clock, 20 ns period.
   always #10 clk = ~clk;

   // Count rising edges so the monitor can check strobe timing.
   always @(posedge clk) clk_edges <= clk_edges + 1;

   gyruss_audio_decim #(.LOG2_DIV(10), .DC_EN(1'b0), .DCB_SHIFT(10)) dut0 (
      .clk(clk), .reset(reset), .in(in_s), .mute(mute),
      .out(out0), .out_valid(valid0)
   );

   gyruss_audio_decim #(.LOG2_DIV(10), .DC_EN(1'b1), .DCB_SHIFT(10)) dut1 (
      .clk(clk), .reset(reset), .in(in_s), .mute(mute),
      .out(out1), .out_valid(valid1)
   );

   // One comparison: count it, and report it if it fails.
   task automatic checkOutput(input string name, input int dut,
                              input logic signed [31:0] got,
                              input logic signed [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, dut, got, want);
      end
   endtask

   // Run one 1024-clock window. alt selects alternating +32767/-32768.
   // mute_out is applied for the output edge of this window, which is the
   // first edge of the next one.
   task automatic applyStimulus(input bit alt, input logic signed [15:0] val,
                                input bit mute_out,
                                input logic signed [15:0] exp0,
                                input logic signed [15:0] exp1);
      exp_t e;
      e.idx = win_idx;
      e.at  = clk_edges + 1025;
      e.val = exp0;
      q0.push_back(e);
      e.val = exp1;
      q1.push_back(e);
      win_idx++;
      for (int i = 0; i < 1024; i++) begin
         if (alt) in_s = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
         else     in_s = val;
         @(negedge clk);
      end
      mute = mute_out;
   endtask

   // Scoreboard monitor for both DUTs.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         last0 = '0;
         last1 = '0;
      end else begin
         if (valid0) begin
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected pulse dut0 at edge %0d, out %0d", clk_edges, out0);
            end else begin
               e = q0.pop_front();
               checkOutput($sformatf("win%0d out", e.idx), 0, out0, e.val);
               checkOutput($sformatf("win%0d pulse edge", e.idx), 0, clk_edges, e.at);
               last0 = out0;
            end
         end else begin
            checkOutput("hold", 0, out0, last0);
         end
         if (valid1) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected pulse dut1 at edge %0d, out %0d", clk_edges, out1);
            end else begin
               e = q1.pop_front();
               checkOutput($sformatf("win%0d out", e.idx), 1, out1, e.val);
               checkOutput($sformatf("win%0d pulse edge", e.idx), 1, clk_edges, e.at);
               last1 = out1;
            end
         end else begin
            checkOutput("hold", 1, out1, last1);
         end
      end
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at edge %0d", clk_edges);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      mute  = 1'b0;
      in_s  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset out", 0, out0, 0);
      checkOutput("reset out", 1, out1, 0);
      checkOutput("reset valid", 0, 32'(valid0), 0);
      checkOutput("reset valid", 1, 32'(valid1), 0);
      reset = 1'b0;

      // Constant, negative, and alternating full-scale inputs.
      applyStimulus(1'b0, 16'sd1000, 1'b0, 16'sd1000, 16'sd1000);
      applyStimulus(1'b0, 16'sd1000, 1'b0, 16'sd1000, 16'sd1000);
      applyStimulus(1'b0, -16'sd1,   1'b0, -16'sd1,   -16'sd1);
      applyStimulus(1'b1, 16'sd0,    1'b0, -16'sd1,   16'sd0);

      // Partial window at cnt=500, then asynchronous reset between edges.
      for (int i = 0; i < 500; i++) begin
         in_s = 16'sd20000;
         @(negedge clk);
      end
      #2;
      reset = 1'b1;
      in_s  = '0;
      #1;
      checkOutput("async reset out", 0, out0, 0);
      checkOutput("async reset out", 1, out1, 0);
      checkOutput("async reset valid", 0, 32'(valid0), 0);
      checkOutput("async reset valid", 1, 32'(valid1), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Post-reset window: only post-reset samples count.
      applyStimulus(1'b0, 16'sd0,    1'b0, 16'sd0,    16'sd0);
      // Step to 8000, DC blocker leaks 7 per window.
      applyStimulus(1'b0, 16'sd8000, 1'b0, 16'sd8000, 16'sd8000);
      applyStimulus(1'b0, 16'sd8000, 1'b0, 16'sd8000, 16'sd7993);
      applyStimulus(1'b0, 16'sd8000, 1'b0, 16'sd8000, 16'sd7986);
      // Mute on one output edge, then release.
      applyStimulus(1'b0, 16'sd8000, 1'b1, 16'sd0,    16'sd0);
      applyStimulus(1'b0, 16'sd8000, 1'b0, 16'sd8000, 16'sd0);
      applyStimulus(1'b0, 16'sd0,    1'b0, 16'sd0,    -16'sd8000);
      applyStimulus(1'b0, 16'sd0,    1'b1, 16'sd0,    16'sd0);
      // Saturation at both rails.
      applyStimulus(1'b0, 16'sd32767, 1'b0, 16'sd32767, 16'sd32767);
      applyStimulus(1'b0, 16'sh8000,  1'b0, 16'sh8000,  16'sh8000);
      applyStimulus(1'b0, 16'sh8000,  1'b0, 16'sh8000,  -16'sd32736);
      applyStimulus(1'b0, 16'sd32767, 1'b0, 16'sd32767, 16'sd32767);

      in_s = '0;
      repeat (20) @(negedge clk);
      checkOutput("pending expectations", 0, q0.size(), 0);
      checkOutput("pending expectations", 1, q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
